// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath/memory.
// The controller side is the master: it receives opcode and memory ready, and drives every enable.
interface multicycle_control_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               ior_d;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               ir_write;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic               imm_zero_ext;
  logic [1:0]         alu_src_b;
  logic [1:0]         pc_source;
  logic [2:0]         alu_op;
  logic [3:0]         state;
  logic               fault;
  logic [1:0]         fault_code;
  logic [COUNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, ior_d, mem_read, mem_write, mem_to_reg, ir_write,
           reg_dst, reg_write, alu_src_a, imm_zero_ext, alu_src_b, pc_source, alu_op,
           state, fault, fault_code, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, ior_d, mem_read, mem_write, mem_to_reg, ir_write,
           reg_dst, reg_write, alu_src_a, imm_zero_ext, alu_src_b, pc_source, alu_op,
           state, fault, fault_code, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control: Moore FSM with memory wait timeout, sticky fault
// and a retired-instruction counter.
module multicycle_control #(
  parameter int COUNT_W     = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                  clk_i,
  input logic                  rst_i,
  multicycle_control_if.master bus
);
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADDR = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_REX     = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_JMP     = 4'd9;
  localparam logic [3:0] S_IEX     = 4'd10;
  localparam logic [3:0] S_IWB     = 4'd11;
  localparam logic [3:0] S_FAULT   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam int              WAIT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic [3:0]         state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [COUNT_W-1:0] retired_q, retired_d;
  logic [1:0]         fault_code_q, fault_code_d;
  logic               mem_state, stall, timeout, retire;
  logic [2:0]         imm_alu_op;
  logic               imm_zx;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    fault_code_d = fault_code_q;
    retire       = 1'b0;
    mem_state    = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    stall        = mem_state && !bus.mem_ready;
    timeout      = stall && (MEM_TIMEOUT != 0) && (wait_q == WAIT_MAX);
    case (state_q)
      S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = bus.opcode;
        case (bus.opcode)
          OP_RTYPE:                                 state_d = S_REX;
          OP_LW, OP_SW:                             state_d = S_MEMADDR;
          OP_BEQ:                                   state_d = S_BEQ;
          OP_J:                                     state_d = S_JMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: state_d = S_IEX;
          default: begin
            state_d      = S_FAULT;
            fault_code_d = 2'b01;
          end
        endcase
      end
      S_MEMADDR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: if (bus.mem_ready) begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_REX:     state_d = S_RWB;
      S_IEX:     state_d = S_IWB;
      S_RWB, S_BEQ, S_JMP, S_IWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_FAULT;
    endcase
    // A ready in the final allowed cycle completes the access because timeout needs a stall.
    if (timeout) begin
      state_d      = S_FAULT;
      fault_code_d = 2'b10;
    end
    wait_d    = (stall && (MEM_TIMEOUT != 0) && (state_d == state_q)) ? wait_q + 1'b1 : '0;
    retired_d = retire ? retired_q + 1'b1 : retired_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_FETCH;
      op_q         <= '0;
      wait_q       <= '0;
      retired_q    <= '0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wait_q       <= wait_d;
      retired_q    <= retired_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    imm_alu_op = 3'b000;
    imm_zx     = 1'b0;
    case (op_q)
      OP_ANDI: begin imm_alu_op = 3'b011; imm_zx = 1'b1; end
      OP_ORI:  begin imm_alu_op = 3'b100; imm_zx = 1'b1; end
      OP_SLTI: imm_alu_op = 3'b101;
      OP_LUI:  imm_alu_op = 3'b110;
      default: imm_alu_op = 3'b000;
    endcase
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.ior_d         = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.imm_zero_ext  = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.alu_op        = 3'b000;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE:  bus.alu_src_b = 2'b11;
      S_MEMADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.ior_d     = 1'b1;
      end
      S_REX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b010;
      end
      S_RWB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
      end
      S_BEQ: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 3'b001;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
      end
      S_JMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
      end
      S_IEX: begin
        bus.alu_src_a    = 1'b1;
        bus.alu_src_b    = 2'b10;
        bus.alu_op       = imm_alu_op;
        bus.imm_zero_ext = imm_zx;
      end
      S_IWB: begin
        bus.reg_write    = 1'b1;
        bus.alu_op       = imm_alu_op;
        bus.imm_zero_ext = imm_zx;
      end
      default: ;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.fault      = (state_q == S_FAULT);
  assign bus.fault_code = fault_code_q;
  assign bus.retired    = retired_q;
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle successor to the single-cycle MIPS main decoder. A Moore-style FSM sequences each instruction through fetch, decode, execute, memory and writeback over several clocks, and drives all datapath enables. It adds a memory ready/wait handshake with a timeout, a sticky fault state for illegal opcodes and timeouts, and a retired-instruction counter. It sits between the instruction register opcode and the shared-memory multi-cycle datapath.

## Interface
- COUNT_W, 32: width of retired-instruction counter.
- MEM_TIMEOUT, 15: max wait cycles per memory access; 0 disables timeout.
- Clock in 1: single clock, all state updates on rising edge.
- Reset in 1: synchronous, active-high.
- Opcode in 6: IR[31:26], valid from DECODE onward.
- MemReady in 1: memory completes current access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA, ImmZeroExt out 1 each: datapath enables.
- ALUSrcB out 2: 00 reg B, 01 const 4, 10 sign/zero-ext imm, 11 imm<<2.
- PCSource out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp out 3: 000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt, 110 lui.
- State out 4: current state encoding.
- Fault out 1; FaultCode out 2: 00 none, 01 illegal opcode, 10 memory timeout.
- Retired out COUNT_W: instructions completed.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, RWB 7, BEQ 8, JMP 9, IEX 10, IWB 11, FAULT 15.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00. IRWrite and PCWrite are 1 only in cycles where MemReady=1. Go to DECODE on MemReady, else hold.
- DECODE: ALUSrcB=11, ALUOp=000 (branch target). Dispatch: 000000->REX; 100011,101011->MEMADDR; 000100->BEQ; 000010->JMP; 001000,001100,001101,001010,001111->IEX; any other opcode->FAULT with FaultCode=01.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Goes to MEMWB on MemReady.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Goes to FETCH on MemReady.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=010. RWB: RegDst=1, RegWrite=1, MemtoReg=0.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01. JMP: PCWrite=1, PCSource=10.
- IEX: ALUSrcA=1, ALUSrcB=10. ALUOp is addi 000, andi 011, ori 100, slti 101, lui 110. ImmZeroExt=1 for andi and ori. IWB: RegWrite=1, RegDst=0, MemtoReg=0. ALUOp and ImmZeroExt are held from IEX.
- Unlisted outputs are 0 in each state.
- Retired increments by 1 on the exit edge of MEMWB, MEMWR (with MemReady), RWB, BEQ, JMP and IWB. It wraps modulo 2^COUNT_W.
- Wait counter resets to 0 on entry to each memory state and counts cycles with MemReady=0. When it reaches MEM_TIMEOUT with MemReady still 0, the FSM goes to FAULT with FaultCode=10. MemReady=1 in that same cycle wins, and the access completes.
- FAULT: all enables 0, Fault=1, FaultCode held. The FSM stays in FAULT until Reset.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.

## Timing
- Reset (synchronous, Reset=1 at an edge) sets State=FETCH, Retired=0, Fault=0, FaultCode=00 and the wait counter to 0. Reset overrides every transition, including from FAULT and mid-access.
- Outputs are decoded from State. The only exceptions are IRWrite and PCWrite in FETCH, which are gated by MemReady combinationally.
- Cycles per instruction with zero-wait memory (MemReady=1 at first cycle): lw 5, sw 4, R-type 4, imm 4, beq 3, j 3. Each wait cycle on an access adds 1.
- Opcode is sampled only in DECODE and held by the datapath's IR afterwards.

## Test plan
- Reset, then Reset=0 with MemReady=0 -> State=0, MemRead=1, IRWrite=0, Retired=0, Fault=0. The FSM holds in FETCH.
- MemReady=1 constant, Opcode=000000 -> states 0,1,6,7,0. RegWrite=1 only in state 7, and Retired=1 after 4 cycles.
- lw with MemReady low for 2 cycles in MEMRD -> 7 cycles total, MemtoReg=1 in MEMWB, Retired increments once.
- Opcode=001101 (ori) -> IEX shows ALUOp=100 and ImmZeroExt=1. IWB keeps the same ALUOp with RegWrite=1.
- Opcode=111111 -> FAULT, Fault=1, FaultCode=01, all enables 0. It stays in FAULT for 20 cycles, then Reset returns it to FETCH. Separately, MemReady=0 in FETCH with MEM_TIMEOUT=15 -> FAULT with FaultCode=10.
- COUNT_W=4, 17 j instructions -> Retired=1 (wraps). Reset asserted in MEMRD -> next state FETCH and Retired=0.
